// File: rtl/led_blink_multi.sv
// led_blink_multi: one shared millisecond prescaler feeding N_CH independent
// LED channels. Each channel holds its own mode (OFF, ON, BLINK, BURST),
// on/off durations in ms and a burst pulse count, loaded through a one-cycle
// write port.
//
// Handshake: cfg_we is a single-cycle strobe with no ready/backpressure; the
// addressed channel (cfg_ch < N_CH) accepts the config on the clock edge
// where cfg_we is high, and its outputs reflect the new mode one cycle later.
// Writes to cfg_ch >= N_CH are dropped.
//
// Per-channel state (FSM state, config, phase timer, pulse counter) lives in
// the packed struct g_ch[i].ch_q so checkers can bind to it directly.
module led_blink_multi #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int N_CH     = 4,
  parameter int RATE_W   = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [RATE_W-1:0] cfg_on_ms,
  input  logic [RATE_W-1:0] cfg_off_ms,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   done,
  output logic              tick_ms
);

  localparam int DIV  = CLK_FREQ / 1000;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  typedef struct packed {
    state_e              state;
    mode_e               mode;
    logic [RATE_W-1:0]   on_ms;
    logic [RATE_W-1:0]   off_ms;
    logic [CNT_W-1:0]    count;
    logic [RATE_W-1:0]   timer;
    logic [CNT_W-1:0]    pulses;
    logic                led;
    logic                done;
  } ch_t;

  // Shared prescaler: free-running, never restarted by config writes.
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;

  // Prescaler next state: wrap at DIV-1 and flag the wrap for one cycle.
  always_comb begin
    ps_d   = (ps_q == PS_MAX) ? '0 : ps_q + PS_W'(1);
    tick_d = (ps_q == PS_MAX);
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
    end
  end

  assign tick_ms = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_t               ch_q, ch_d;
    logic              wr_hit;
    logic [RATE_W-1:0] on_lim, off_lim;

    assign wr_hit  = cfg_we && (cfg_ch == 4'(g));
    // A zero duration behaves as 1 ms, so the compare limit floors at 0.
    assign on_lim  = (ch_q.on_ms  == '0) ? '0 : ch_q.on_ms  - RATE_W'(1);
    assign off_lim = (ch_q.off_ms == '0) ? '0 : ch_q.off_ms - RATE_W'(1);

    // Channel next state: a write overrides everything (including a
    // coincident tick); otherwise ticks advance the HIGH/LOW phases.
    always_comb begin
      ch_d      = ch_q;
      ch_d.done = 1'b0;
      if (wr_hit) begin
        ch_d.mode   = mode_e'(cfg_mode);
        ch_d.on_ms  = cfg_on_ms;
        ch_d.off_ms = cfg_off_ms;
        ch_d.count  = cfg_count;
        ch_d.timer  = '0;
        ch_d.pulses = '0;
        case (mode_e'(cfg_mode))
          MODE_OFF: begin
            ch_d.state = ST_IDLE;
            ch_d.led   = 1'b0;
          end
          MODE_ON: begin
            ch_d.state = ST_IDLE;
            ch_d.led   = 1'b1;
          end
          MODE_BLINK: begin
            ch_d.state = ST_HIGH;
            ch_d.led   = 1'b1;
          end
          default: begin
            // A zero-length burst completes immediately.
            if (cfg_count == '0) begin
              ch_d.state = ST_IDLE;
              ch_d.led   = 1'b0;
              ch_d.done  = 1'b1;
            end else begin
              ch_d.state = ST_HIGH;
              ch_d.led   = 1'b1;
            end
          end
        endcase
      end else if (tick_q) begin
        case (ch_q.state)
          ST_HIGH: begin
            if (ch_q.timer == on_lim) begin
              ch_d.state = ST_LOW;
              ch_d.led   = 1'b0;
              ch_d.timer = '0;
              if (ch_q.mode == MODE_BURST) begin
                ch_d.pulses = ch_q.pulses + CNT_W'(1);
              end
            end else begin
              ch_d.timer = ch_q.timer + RATE_W'(1);
            end
          end
          ST_LOW: begin
            if (ch_q.timer == off_lim) begin
              ch_d.timer = '0;
              if (ch_q.mode == MODE_BURST && ch_q.pulses == ch_q.count) begin
                ch_d.state = ST_IDLE;
                ch_d.led   = 1'b0;
                ch_d.done  = 1'b1;
              end else begin
                ch_d.state = ST_HIGH;
                ch_d.led   = 1'b1;
              end
            end else begin
              ch_d.timer = ch_q.timer + RATE_W'(1);
            end
          end
          default: begin
            ch_d.timer = ch_q.timer;
          end
        endcase
      end
    end

    // Channel state register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ch_q <= '0;
      end else begin
        ch_q <= ch_d;
      end
    end

    assign led[g]  = ch_q.led;
    assign busy[g] = (ch_q.state != ST_IDLE);
    assign done[g] = ch_q.done;
  end

endmodule

// File: doc/led_blink_multi.md
Name: led_blink_multi

Overview:
- Multi-channel successor to the single-LED blinker. One shared millisecond prescaler drives N_CH independent LED channels.
- Each channel has its own on-time, off-time and mode: off, on, continuous blink, or a counted burst.
- Channels are configured through a one-cycle write port from the control/register block. LED outputs drive board pins directly.

Parameters:
- CLK_FREQ, 100_000_000, clk frequency in Hz; CLK_FREQ/1000 must be an integer of at least 2.
- N_CH, 4, number of LED channels (1..16).
- RATE_W, 16, width of on/off durations in ms.
- CNT_W, 8, width of the burst pulse count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  one-cycle write strobe
- cfg_ch  in  4  target channel; writes with cfg_ch >= N_CH are ignored
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
- cfg_on_ms  in  RATE_W  high-phase duration in ms
- cfg_off_ms  in  RATE_W  low-phase duration in ms
- cfg_count  in  CNT_W  number of high pulses in BURST
- led  out  N_CH  LED drive, registered
- busy  out  N_CH  channel in BLINK or BURST activity
- done  out  N_CH  one-cycle pulse when a BURST completes
- tick_ms  out  1  one-cycle pulse every CLK_FREQ/1000 clocks

Behaviour:
- Reset: all outputs 0, prescaler 0, every channel in IDLE with mode OFF and all stored config cleared.
- Prescaler:
  - Counts 0..CLK_FREQ/1000-1 and wraps.
  - tick_ms is registered and is high for the one cycle after the counter reaches its maximum.
  - Free-running; not restarted by writes.
- Config write:
  - On cfg_we, channel cfg_ch latches mode, on, off and count. Its phase timer and pulse counter clear.
  - The new state takes effect in the next cycle, so led reflects the new mode one cycle after the write.
  - A write overrides any activity in progress, including a BURST in progress; no done pulse is issued for the aborted burst.
- Duration rule: an on_ms or off_ms of 0 is treated as 1 ms. The timer compares against max(dur,1)-1.
- Per-channel FSM, with states IDLE, HIGH, LOW:
  - OFF: IDLE, led=0, busy=0.
  - ON: IDLE, led=1, busy=0.
  - BLINK:
    - Write → HIGH, led=1, busy=1.
    - HIGH → LOW when tick_ms and timer==on-1; led=0 and the timer clears.
    - LOW → HIGH when tick_ms and timer==off-1; led=1.
    - Repeats forever.
  - BURST:
    - Same HIGH/LOW sequencing as BLINK. The pulse counter increments on each HIGH→LOW transition.
    - On the LOW exit where pulses==count: go to IDLE, led=0, busy=0, done=1 for exactly one cycle. The mode stays BURST but the channel is inactive until the next write.
    - count==0: the cycle after the write, go to IDLE with led=0 and busy=0, and pulse done for that cycle.
- Timer:
  - Increments only on tick_ms while in HIGH or LOW.
  - Width RATE_W; it never wraps because the compare against dur-1 always fires first.
- Phase length: the first phase after a write lasts between on-1 and on ms, because the prescaler is shared and free-running. All later phases last exactly on or off ms, i.e. on×CLK_FREQ/1000 clocks.
- Simultaneous events:
  - A write in the same cycle as tick_ms to the same channel: the write wins and the tick is ignored for that channel.
  - Other channels are unaffected by that write.
- Reset asserted mid-operation: immediate return to reset values. After reset, channels stay OFF until written.

Test Plan (CLK_FREQ=10_000, i.e. 10 clocks per ms; N_CH=4):
- Reset release: tick_ms pulses every 10 clocks exactly; led, busy and done all 0 with no writes for 200 clocks.
- ch0 BLINK on=3 off=2 → led[0] rises 1 cycle after the write. After the first phase, high lasts 30 clocks and low 20 clocks, for 5 periods. busy[0]=1 throughout.
- ch1 BURST on=1 off=1 count=3 → exactly 3 high pulses. done[1] is high for 1 cycle at the end of the 3rd low phase, then led[1]=0 and busy[1]=0 and stay so.
- ch2 BURST count=0 → done[2] pulses the cycle after the write; led[2] never rises. Also ch3 ON → led[3]=1 one cycle after the write; then ch3 OFF → led[3]=0 one cycle after that write.
- Write ch0 BLINK on=0 off=0 → toggles every 10 clocks (1 ms), with no stall or timer wrap. Rewrite ch1 mid-BURST with OFF → led[1]=0 next cycle and no done pulse. Write with cfg_ch=5 → no channel changes.
- Assert reset mid-BLINK, and a write coinciding with tick_ms → all outputs 0 immediately on reset. The written channel restarts its phase timer from 0 and ignores the coincident tick.
